// File: rtl/fru_cfg_loader.sv
// Serial shadow-register loader for the FRU PLA configuration (RegMux, minterm OR mask).
// Optional FRU_CFG_PARITY_EN appends an even-parity bit to each frame and checks it at commit.
module fru_cfg_loader #(
    parameter int INPUT_SIZE   = 2,
    parameter int SEGMENT_SIZE = 2,
    localparam int SEL_W       = $clog2(INPUT_SIZE),
    localparam int CFG_W       = SEGMENT_SIZE*SEL_W + 2**SEGMENT_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 CfgStart,
    input  logic                                 CfgValid,
    input  logic                                 CfgBit,
    output logic                                 CfgReady,
    input  logic                                 CfgCommit,
    output logic [SEGMENT_SIZE-1:0][SEL_W-1:0]   RegMux,
    output logic [2**SEGMENT_SIZE-1:0]           RegMintermORSelect,
    output logic                                 CfgLoaded,
    output logic                                 CfgActive,
    output logic                                 CfgErr
);

    localparam int MUX_W = SEGMENT_SIZE*SEL_W;
    localparam int OR_W  = 2**SEGMENT_SIZE;
`ifdef FRU_CFG_PARITY_EN
    localparam int FRAME_W = CFG_W + 1;
`else
    localparam int FRAME_W = CFG_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [FRAME_W-1:0] shadow;
    logic               par_ok;

`ifdef FRU_CFG_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(^shadow);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            count              <= '0;
            shadow             <= '0;
            RegMux             <= '0;
            RegMintermORSelect <= '0;
            CfgReady           <= 1'b0;
            CfgLoaded          <= 1'b0;
            CfgActive          <= 1'b0;
            CfgErr             <= 1'b0;
        end else if (CfgStart) begin
            // Start wins over a simultaneous commit; the held frame is dropped.
            state     <= SHIFT;
            count     <= '0;
            shadow    <= '0;
            CfgErr    <= 1'b0;
            CfgReady  <= 1'b1;
            CfgLoaded <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CfgCommit) CfgErr <= 1'b1;
                end
                SHIFT: begin
                    if (CfgCommit) begin
                        CfgErr <= 1'b1;
                    end else if (CfgValid && CfgReady) begin
                        shadow <= shadow | (FRAME_W'(CfgBit) << count);
                        count  <= count + CNT_W'(1);
                        if (count == CNT_W'(FRAME_W - 1)) begin
                            state     <= FULL;
                            CfgReady  <= 1'b0;
                            CfgLoaded <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (CfgCommit) begin
                        state     <= IDLE;
                        CfgLoaded <= 1'b0;
                        if (par_ok) begin
                            RegMux             <= shadow[MUX_W-1:0];
                            RegMintermORSelect <= shadow[MUX_W +: OR_W];
                            CfgActive          <= 1'b1;
                        end else begin
                            CfgErr <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    CfgReady  <= 1'b0;
                    CfgLoaded <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fru_cfg_loader.sv
// Directed bench for fru_cfg_loader at INPUT_SIZE=4, SEGMENT_SIZE=2.
// Parity scenarios are exercised only when FRU_CFG_PARITY_EN is defined.
module tb_fru_cfg_loader;

    localparam int INPUT_SIZE   = 4;
    localparam int SEGMENT_SIZE = 2;
    localparam int SEL_W        = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic CfgStart = 1'b0;
    logic CfgValid = 1'b0;
    logic CfgBit = 1'b0;
    logic CfgCommit = 1'b0;
    logic CfgReady;
    logic [SEGMENT_SIZE-1:0][SEL_W-1:0] RegMux;
    logic [2**SEGMENT_SIZE-1:0] RegMintermORSelect;
    logic CfgLoaded;
    logic CfgActive;
    logic CfgErr;

    int tests = 0;
    int fails = 0;

    fru_cfg_loader #(
        .INPUT_SIZE(INPUT_SIZE),
        .SEGMENT_SIZE(SEGMENT_SIZE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .CfgStart(CfgStart),
        .CfgValid(CfgValid),
        .CfgBit(CfgBit),
        .CfgReady(CfgReady),
        .CfgCommit(CfgCommit),
        .RegMux(RegMux),
        .RegMintermORSelect(RegMintermORSelect),
        .CfgLoaded(CfgLoaded),
        .CfgActive(CfgActive),
        .CfgErr(CfgErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        CfgValid = 1'b1;
        CfgBit   = b;
        step();
        CfgValid = 1'b0;
        CfgBit   = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_range(input logic [7:0] d, input int lo,
                              input int hi, input int gap);
        for (int i = lo; i <= hi; i++) send_bit(d[i], gap);
    endtask

    task automatic finish_frame(input logic [7:0] d);
`ifdef FRU_CFG_PARITY_EN
        send_bit(^d, 0);
`else
        if (d === 8'hxx) send_bit(1'b0, 0);
`endif
    endtask

    task automatic pulse_start();
        CfgStart = 1'b1;
        step();
        CfgStart = 1'b0;
    endtask

    task automatic pulse_commit();
        CfgCommit = 1'b1;
        step();
        CfgCommit = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk_cfg(input string tag, input logic [1:0] m0,
                           input logic [1:0] m1, input logic [3:0] orm);
        chk({tag, "_mux0"}, 32'(RegMux[0]), 32'(m0));
        chk({tag, "_mux1"}, 32'(RegMux[1]), 32'(m1));
        chk({tag, "_or"}, 32'(RegMintermORSelect), 32'(orm));
    endtask

    initial begin
        // Reset state
        #1;
        chk_cfg("rst", 2'd0, 2'd0, 4'h0);
        chk("rst_ready", 32'(CfgReady), 32'd0);
        chk("rst_loaded", 32'(CfgLoaded), 32'd0);
        chk("rst_active", 32'(CfgActive), 32'd0);
        chk("rst_err", 32'(CfgErr), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic load of 8'hA6
        pulse_start();
        chk("basic_ready", 32'(CfgReady), 32'd1);
        send_range(8'hA6, 0, 6, 0);
        chk("basic_loaded7", 32'(CfgLoaded), 32'd0);
        send_range(8'hA6, 7, 7, 0);
        finish_frame(8'hA6);
        chk("basic_loaded", 32'(CfgLoaded), 32'd1);
        chk("basic_ready_full", 32'(CfgReady), 32'd0);
        chk_cfg("basic_precommit", 2'd0, 2'd0, 4'h0);
        pulse_commit();
        chk_cfg("basic", 2'd2, 2'd1, 4'hA);
        chk("basic_active", 32'(CfgActive), 32'd1);
        chk("basic_err", 32'(CfgErr), 32'd0);
        chk("basic_loaded_clr", 32'(CfgLoaded), 32'd0);

        // Valid in IDLE is ignored
        send_bit(1'b1, 0);
        chk("idle_ready", 32'(CfgReady), 32'd0);
        chk("idle_loaded", 32'(CfgLoaded), 32'd0);

        // Backpressure with 3-cycle gaps
        do_reset();
        pulse_start();
        send_range(8'hA6, 0, 6, 3);
        chk("bp_ready_gap", 32'(CfgReady), 32'd1);
        chk("bp_loaded7", 32'(CfgLoaded), 32'd0);
        send_range(8'hA6, 7, 7, 0);
        finish_frame(8'hA6);
        chk("bp_loaded", 32'(CfgLoaded), 32'd1);
        pulse_commit();
        chk_cfg("bp", 2'd2, 2'd1, 4'hA);
        chk("bp_active", 32'(CfgActive), 32'd1);

        // Premature commit after 5 bits
        do_reset();
        pulse_start();
        send_range(8'hA6, 0, 4, 0);
        pulse_commit();
        chk("pre_err", 32'(CfgErr), 32'd1);
        chk_cfg("pre_hold", 2'd0, 2'd0, 4'h0);
        chk("pre_active", 32'(CfgActive), 32'd0);
        chk("pre_ready", 32'(CfgReady), 32'd1);
        send_range(8'hA6, 5, 7, 0);
        finish_frame(8'hA6);
        chk("pre_loaded", 32'(CfgLoaded), 32'd1);
        pulse_commit();
        chk_cfg("pre_apply", 2'd2, 2'd1, 4'hA);
        chk("pre_err_sticky", 32'(CfgErr), 32'd1);
        chk("pre_active2", 32'(CfgActive), 32'd1);
        pulse_start();
        chk("pre_err_clr", 32'(CfgErr), 32'd0);

        // Start beats commit in FULL
        send_range(8'h3F, 0, 7, 0);
        finish_frame(8'h3F);
        chk("prio_full", 32'(CfgLoaded), 32'd1);
        CfgStart  = 1'b1;
        CfgCommit = 1'b1;
        step();
        CfgStart  = 1'b0;
        CfgCommit = 1'b0;
        chk("prio_err", 32'(CfgErr), 32'd0);
        chk("prio_ready", 32'(CfgReady), 32'd1);
        chk("prio_loaded", 32'(CfgLoaded), 32'd0);
        chk_cfg("prio_hold", 2'd2, 2'd1, 4'hA);
        send_range(8'h5C, 0, 7, 1);
        finish_frame(8'h5C);
        pulse_commit();
        chk_cfg("prio_new", 2'd0, 2'd3, 4'h5);
        chk("prio_err2", 32'(CfgErr), 32'd0);

        // Reset mid-frame
        pulse_start();
        send_range(8'hA6, 0, 3, 0);
        rst_n = 1'b0;
        #1;
        chk_cfg("mrst", 2'd0, 2'd0, 4'h0);
        chk("mrst_ready", 32'(CfgReady), 32'd0);
        chk("mrst_active", 32'(CfgActive), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_bit(1'b1, 0);
        chk("mrst_ready_post", 32'(CfgReady), 32'd0);
        chk("mrst_loaded_post", 32'(CfgLoaded), 32'd0);
        pulse_start();
        chk("mrst_ready_start", 32'(CfgReady), 32'd1);
        send_range(8'hA6, 0, 6, 0);
        chk("mrst_loaded7", 32'(CfgLoaded), 32'd0);
        send_range(8'hA6, 7, 7, 0);
        finish_frame(8'hA6);
        chk("mrst_loaded", 32'(CfgLoaded), 32'd1);

`ifdef FRU_CFG_PARITY_EN
        // Wrong then correct parity
        pulse_start();
        send_range(8'hA6, 0, 7, 0);
        send_bit(1'b1, 0);
        pulse_commit();
        chk("par_bad_err", 32'(CfgErr), 32'd1);
        chk_cfg("par_bad", 2'd0, 2'd0, 4'h0);
        chk("par_bad_active", 32'(CfgActive), 32'd0);
        chk("par_bad_idle", 32'(CfgLoaded), 32'd0);
        pulse_start();
        send_range(8'hA6, 0, 7, 0);
        send_bit(1'b0, 0);
        pulse_commit();
        chk("par_ok_err", 32'(CfgErr), 32'd0);
        chk_cfg("par_ok", 2'd2, 2'd1, 4'hA);
        chk("par_ok_active", 32'(CfgActive), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fru_cfg_loader.md
FRU_CFG_LOADER -- requirements
Module: fru_cfg_loader

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 2, meaning the width of the PLA trigger input vector being configured.
REQ-002 SHALL have parameter SEGMENT_SIZE, default 2, meaning the number of selected PLA inputs.
REQ-003 SHALL define derived constants SEL_W = $clog2(INPUT_SIZE) and CFG_W = SEGMENT_SIZE*SEL_W + 2**SEGMENT_SIZE.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port CfgStart, input, 1, a one-cycle pulse that opens a new configuration frame.
REQ-008 SHALL have port CfgValid, input, 1, indicating that CfgBit is valid.
REQ-009 SHALL have port CfgBit, input, 1, the serial configuration bit, sent LSB first.
REQ-010 SHALL have port CfgReady, output, 1, indicating that the loader accepts a bit this cycle.
REQ-011 SHALL have port CfgCommit, input, 1, a one-cycle pulse that requests transfer of the shadow frame to the active outputs.
REQ-012 SHALL have port RegMux, output, [SEGMENT_SIZE-1:0][SEL_W-1:0], the active input-select configuration driven to the PLA.
REQ-013 SHALL have port RegMintermORSelect, output, [2**SEGMENT_SIZE-1:0], the active minterm OR mask driven to the PLA.
REQ-014 SHALL have port CfgLoaded, output, 1, indicating that a complete frame is held and awaiting commit.
REQ-015 SHALL have port CfgActive, output, 1, indicating that at least one commit has succeeded since reset.
REQ-016 SHALL have port CfgErr, output, 1, a sticky flag indicating that a commit was rejected.

Function
REQ-017 SHALL implement an FSM with states IDLE, SHIFT and FULL, where CfgReady=1 only in SHIFT and CfgLoaded=1 only in FULL.
REQ-018 SHALL, on CfgStart in any state, go to SHIFT, clear the bit counter and shadow register, and clear CfgErr.
REQ-019 SHALL, in SHIFT, accept a bit only when CfgValid&&CfgReady, write it to shadow[count] and increment count; CfgValid=0 cycles SHALL hold state.
REQ-020 SHALL go from SHIFT to FULL on the cycle following acceptance of the final frame bit (count = FRAME_W-1).
REQ-021 SHALL ignore CfgValid outside SHIFT.
REQ-022 SHALL map shadow bits [SEGMENT_SIZE*SEL_W-1:0] to packed RegMux, with RegMux[0] in the LSBs.
REQ-023 SHALL map the next 2**SEGMENT_SIZE shadow bits to RegMintermORSelect.
REQ-024 SHALL, on CfgCommit in FULL, load the active registers from shadow, set CfgActive=1 and return to IDLE, with the outputs taking the new values on the cycle after CfgCommit is sampled (1-cycle latency).
REQ-025 SHALL, on CfgCommit in IDLE or SHIFT, set CfgErr=1, leave the active registers unchanged and keep the current state and count.
REQ-026 SHALL give CfgStart priority over a simultaneous CfgCommit: the frame is discarded, no commit occurs and no error is flagged.
REQ-027 SHALL change the active outputs only on a successful commit, never glitching them during shifting.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, count=0, shadow=0, RegMux=0, RegMintermORSelect=0 (PLA output 0), CfgReady=0, CfgLoaded=0, CfgActive=0 and CfgErr=0.
REQ-029 SHALL, when reset is asserted mid-frame, discard the partial frame, and SHALL require a new CfgStart after reset release.

Configuration
REQ-030 SHALL, with FRU_CFG_PARITY_EN defined, use FRAME_W = CFG_W+1, the last bit being even parity over the CFG_W bits.
REQ-031 SHALL, with FRU_CFG_PARITY_EN defined, on a commit with mismatched parity, set CfgErr=1, leave the active registers unchanged and go to IDLE.
REQ-032 SHALL, without FRU_CFG_PARITY_EN, use FRAME_W = CFG_W with no parity check, so that CfgErr arises only from REQ-025.

Verification
REQ-033 SHALL cover basic load (INPUT_SIZE=4, SEGMENT_SIZE=2, no parity): CfgStart, then bits of 8'hA6 LSB first, then CfgCommit -> the next cycle RegMux[0]=2, RegMux[1]=1, RegMintermORSelect=4'hA, CfgActive=1, CfgErr=0.
REQ-034 SHALL cover backpressure: 8'hA6 sent with CfgValid=0 gaps of 3 cycles between bits -> CfgLoaded rises only after the 8th accepted bit, and the outputs after commit match REQ-033.
REQ-035 SHALL cover premature commit: CfgCommit after 5 bits -> CfgErr=1, outputs stay 0; sending the remaining 3 bits then CfgCommit -> config applied while CfgErr stays 1 until the next CfgStart.
REQ-036 SHALL cover restart and priority: CfgStart together with CfgCommit in FULL -> no update and CfgErr=0; a new frame 8'h5C then loads RegMux[0]=0, RegMux[1]=3, RegMintermORSelect=4'h5.
REQ-037 SHALL cover reset mid-frame: rst_n low after 4 bits -> all outputs 0 immediately and CfgReady=0 until CfgStart.
REQ-038 SHALL cover parity (FRU_CFG_PARITY_EN): frame 8'hA6 with parity bit 1 (wrong) then commit -> CfgErr=1, outputs unchanged; the same frame with parity bit 0 -> applied.
